// File: rtl/lebug_pkg.sv
// lebug_pkg: reduce-mode encoding and lane-count helper shared by the packer
package lebug_pkg;
  typedef enum logic [1:0] {RED_N, RED_M, RED_ONE, RED_RSVD} reduce_mode_t;
  typedef enum logic {IDLE, PENDING_EOF} pack_state_t;
  function automatic int lanes_for_mode(reduce_mode_t mode, int n, int m);
    return mode == RED_M ? m : mode == RED_ONE ? 1 : n;
  endfunction
endpackage

// File: rtl/data_packer.sv
// data_packer: densely packs the meaningful low lanes of reduced vectors into full N-lane vectors
//   mode_in/valid_in/eof_in/vector_in : reduced vector, lanes [k-1:0] meaningful
//   valid_out/eof_out/count_out/vector_out : registered packed vector, unused lanes zero
module data_packer
  import lebug_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode_in,
  input  logic                             valid_in,
  input  logic                             eof_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic [$clog2(N):0]               count_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(N) + 1;
  localparam logic [PW:0] FULL = (PW + 1)'(N);
  pack_state_t state, state_d;
  logic [PW-1:0] ptr, ptr_d, kl, emit_cnt;
  logic [PW:0] sum;
  logic [N*DW-1:0] pack_q, pack_d, lane_mask, new_lanes, merged, emit_vec;
  logic emit, emit_eof;
  // Lanes at and above ptr are always zero in pack_q, so OR-ing the shifted new lanes is a safe write mux
  always_comb begin
    kl = PW'(lanes_for_mode(reduce_mode_t'(mode_in), N, M));
    sum = {1'b0, ptr} + {1'b0, kl};
    lane_mask = '0;
    for (int i = 0; i < N; i++) lane_mask[i*DW+:DW] = (i < int'(kl)) ? '1 : '0;
    new_lanes = vector_in & lane_mask;
    merged = pack_q | (new_lanes << (DW * int'(ptr)));
  end
  always_comb begin
    emit = 1'b0;
    emit_eof = 1'b0;
    emit_cnt = ptr;
    emit_vec = pack_q;
    ptr_d = ptr;
    pack_d = pack_q;
    state_d = state;
    if (state == PENDING_EOF) begin
      emit = 1'b1;
      emit_eof = 1'b1;
      ptr_d = '0;
      pack_d = '0;
      state_d = IDLE;
    end else if (valid_in && sum <= FULL) begin
      if (sum == FULL || eof_in) begin
        emit = 1'b1;
        emit_eof = eof_in;
        emit_cnt = sum[PW-1:0];
        emit_vec = merged;
        ptr_d = '0;
        pack_d = '0;
      end else begin
        ptr_d = sum[PW-1:0];
        pack_d = merged;
      end
    end else if (valid_in) begin
      // Mode grew mid-vector: close the partial vector, new lanes start the next one
      emit = 1'b1;
      ptr_d = kl;
      pack_d = new_lanes;
      state_d = eof_in ? PENDING_EOF : IDLE;
    end else if (eof_in && ptr != '0) begin
      emit = 1'b1;
      emit_eof = 1'b1;
      ptr_d = '0;
      pack_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      pack_q <= '0;
      valid_out <= 1'b0;
      eof_out <= 1'b0;
      count_out <= '0;
      vector_out <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      pack_q <= pack_d;
      valid_out <= emit;
      eof_out <= emit & emit_eof;
      if (emit) begin
        count_out <= emit_cnt;
        vector_out <= emit_vec;
      end
    end
  end
endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: directed and randomized checks of data_packer against a lane-queue model
module tb_data_packer;
  localparam int N = 8;
  localparam int M = 4;
  localparam int DW = 32;
  typedef logic [N-1:0][DW-1:0] vec_t;
  logic clk = 0, reset = 1, valid_in = 0, eof_in = 0, valid_out, eof_out;
  logic [1:0] mode_in = 0;
  vec_t vector_in = '0, vector_out;
  logic [$clog2(N):0] count_out;
  int total = 0, bad = 0;
  logic [DW-1:0] q[$];
  bit pend;
  logic exp_valid, exp_eof;
  int exp_cnt;
  vec_t exp_vec;
  data_packer #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .mode_in(mode_in), .valid_in(valid_in), .eof_in(eof_in),
    .vector_in(vector_in), .valid_out(valid_out), .eof_out(eof_out),
    .count_out(count_out), .vector_out(vector_out)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(int k, int a, int inc, bit pad_rand);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = i < k ? 32'(a + i * inc) : (pad_rand ? $urandom() : '0);
    return v;
  endfunction
  task automatic emit_q(bit e);
    exp_valid = 1;
    exp_eof = e;
    exp_cnt = q.size();
    exp_vec = '0;
    foreach (q[i]) exp_vec[i] = q[i];
    q.delete();
  endtask
  task automatic model(logic [1:0] m, logic v, logic e, vec_t d);
    int k = m == 1 ? M : m == 2 ? 1 : N;
    exp_valid = 0;
    exp_eof = 0;
    if (pend) begin
      emit_q(1);
      pend = 0;
    end else if (v) begin
      if (q.size() + k <= N) begin
        for (int i = 0; i < k; i++) q.push_back(d[i]);
        if (q.size() == N || e) emit_q(e);
      end else begin
        emit_q(0);
        for (int i = 0; i < k; i++) q.push_back(d[i]);
        pend = e;
      end
    end else if (e && q.size() != 0) emit_q(1);
  endtask
  task automatic step(logic [1:0] m, logic v, logic e, vec_t d);
    mode_in = m;
    valid_in = v;
    eof_in = e;
    vector_in = d;
    model(m, v, e, d);
    @(posedge clk);
    #1;
    valid_in = 0;
    eof_in = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    valid_in = 1;
    vector_in = mk(8, 1, 1, 0);
    @(posedge clk);
    #1;
    valid_in = 0;
    total += 4;
    if (valid_out !== 0) begin bad++; $display("FAIL reset_valid got=%0b want=0", valid_out); end
    if (eof_out !== 0) begin bad++; $display("FAIL reset_eof got=%0b want=0", eof_out); end
    if (count_out !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_out); end
    if (vector_out !== '0) begin bad++; $display("FAIL reset_vector got=%h want=0", vector_out); end
    reset = 0;
    q.delete();
    pend = 0;
    exp_cnt = 0;
    exp_vec = '0;
  endtask
  task automatic test_pack_m;
    step(1, 1, 0, mk(4, 1, 1, 1));
    total++;
    if (valid_out !== 0) begin bad++; $display("FAIL packm_first got=%0b want=0", valid_out); end
    step(1, 1, 0, mk(4, 5, 1, 1));
    total += 4;
    if (valid_out !== 1) begin bad++; $display("FAIL packm_valid got=%0b want=1", valid_out); end
    if (eof_out !== 0) begin bad++; $display("FAIL packm_eof got=%0b want=0", eof_out); end
    if (count_out !== 8) begin bad++; $display("FAIL packm_count got=%0d want=8", count_out); end
    if (vector_out !== mk(8, 1, 1, 0)) begin bad++; $display("FAIL packm_vector got=%h want=%h", vector_out, mk(8, 1, 1, 0)); end
  endtask
  task automatic test_eof_flush;
    for (int i = 0; i < 3; i++) begin
      step(2, 1, 0, mk(1, 10 + i, 0, 1));
      total++;
      if (valid_out !== 0) begin bad++; $display("FAIL flush_fill%0d got=%0b want=0", i, valid_out); end
    end
    step(2, 0, 1, mk(0, 0, 0, 1));
    total += 4;
    if (valid_out !== 1 || eof_out !== 1) begin bad++; $display("FAIL flush_flags got=%0b%0b want=11", valid_out, eof_out); end
    if (count_out !== 3) begin bad++; $display("FAIL flush_count got=%0d want=3", count_out); end
    if (vector_out !== mk(3, 10, 1, 0)) begin bad++; $display("FAIL flush_vector got=%h want=%h", vector_out, mk(3, 10, 1, 0)); end
    step(2, 0, 1, mk(0, 0, 0, 1));
    if (valid_out !== 0) begin bad++; $display("FAIL flush_ptr_zero got=%0b want=0", valid_out); end
  endtask
  task automatic test_full_eof;
    step(0, 1, 1, mk(8, 'ha0, 1, 0));
    total += 3;
    if (valid_out !== 1 || eof_out !== 1) begin bad++; $display("FAIL fulleof_flags got=%0b%0b want=11", valid_out, eof_out); end
    if (count_out !== 8) begin bad++; $display("FAIL fulleof_count got=%0d want=8", count_out); end
    step(0, 0, 0, '0);
    if (valid_out !== 0) begin bad++; $display("FAIL fulleof_extra got=%0b want=0", valid_out); end
  endtask
  task automatic test_mode_change;
    step(2, 1, 0, mk(1, 7, 0, 1));
    step(1, 1, 0, mk(4, 1, 0, 1));
    total++;
    if (valid_out !== 0) begin bad++; $display("FAIL mchg_packed got=%0b want=0", valid_out); end
    step(1, 1, 0, mk(4, 2, 0, 1));
    total += 3;
    if (valid_out !== 1 || eof_out !== 0) begin bad++; $display("FAIL mchg_flags got=%0b%0b want=10", valid_out, eof_out); end
    if (count_out !== 5) begin bad++; $display("FAIL mchg_count got=%0d want=5", count_out); end
    if (vector_out !== vec_t'({32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd7})) begin bad++; $display("FAIL mchg_vector got=%h", vector_out); end
    step(1, 0, 1, '0);
    total += 2;
    if (count_out !== 4 || eof_out !== 1) begin bad++; $display("FAIL mchg_rest got=%0d/%0b want=4/1", count_out, eof_out); end
    if (vector_out !== mk(4, 2, 0, 0)) begin bad++; $display("FAIL mchg_rest_vector got=%h want=%h", vector_out, mk(4, 2, 0, 0)); end
  endtask
  task automatic test_pending_eof;
    step(2, 1, 0, mk(1, 9, 0, 1));
    step(0, 1, 1, mk(8, 20, 1, 0));
    total += 3;
    if (valid_out !== 1 || eof_out !== 0) begin bad++; $display("FAIL pend_first_flags got=%0b%0b want=10", valid_out, eof_out); end
    if (count_out !== 1) begin bad++; $display("FAIL pend_first_count got=%0d want=1", count_out); end
    if (vector_out !== mk(1, 9, 0, 0)) begin bad++; $display("FAIL pend_first_vector got=%h", vector_out); end
    step(2, 1, 0, mk(1, 55, 0, 1));
    total += 3;
    if (valid_out !== 1 || eof_out !== 1) begin bad++; $display("FAIL pend_second_flags got=%0b%0b want=11", valid_out, eof_out); end
    if (count_out !== 8) begin bad++; $display("FAIL pend_second_count got=%0d want=8", count_out); end
    if (vector_out !== mk(8, 20, 1, 0)) begin bad++; $display("FAIL pend_second_vector got=%h", vector_out); end
    step(2, 0, 1, '0);
    total++;
    if (valid_out !== 0) begin bad++; $display("FAIL pend_ignored got=%0b want=0", valid_out); end
  endtask
  task automatic test_empty_eof;
    step(0, 0, 1, '0);
    total += 2;
    if (valid_out !== 0 || eof_out !== 0) begin bad++; $display("FAIL empty_flags got=%0b%0b want=00", valid_out, eof_out); end
    if (count_out !== 8 || vector_out !== mk(8, 20, 1, 0)) begin bad++; $display("FAIL empty_hold got=%0d/%h", count_out, vector_out); end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      step(2, 1, 0, mk(1, 100 + i, 0, 1));
      total++;
      if (valid_out !== 0) begin bad++; $display("FAIL rmid_fill%0d got=%0b want=0", i, valid_out); end
    end
    #2 reset = 1;
    #1;
    total++;
    if (count_out !== 0 || vector_out !== '0) begin bad++; $display("FAIL rmid_async got=%0d/%h want=0", count_out, vector_out); end
    @(posedge clk);
    #1 reset = 0;
    q.delete();
    pend = 0;
    exp_cnt = 0;
    exp_vec = '0;
    step(2, 0, 1, '0);
    total += 2;
    if (valid_out !== 0) begin bad++; $display("FAIL rmid_eof got=%0b want=0", valid_out); end
    if (count_out !== 0 || vector_out !== '0) begin bad++; $display("FAIL rmid_zero got=%0d/%h want=0", count_out, vector_out); end
  endtask
  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      vec_t d;
      for (int i = 0; i < N; i++) d[i] = $urandom();
      step(2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, d);
      total += 4;
      if (valid_out !== exp_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%0b want=%0b", c, valid_out, exp_valid); end
      if (eof_out !== exp_eof) begin bad++; $display("FAIL rand_eof c=%0d got=%0b want=%0b", c, eof_out, exp_eof); end
      if (count_out !== exp_cnt) begin bad++; $display("FAIL rand_count c=%0d got=%0d want=%0d", c, count_out, exp_cnt); end
      if (vector_out !== exp_vec) begin bad++; $display("FAIL rand_vector c=%0d got=%h want=%h", c, vector_out, exp_vec); end
    end
  endtask
  initial begin
    test_reset;
    test_pack_m;
    test_eof_flush;
    test_full_eof;
    test_mode_change;
    test_pending_eof;
    test_empty_eof;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
